// File: rtl/bidir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bidir_pkg
// Purpose  : Shared definitions for the bidirectional I/O bank.
//            - channel output state encoding (OFF / DRIVE / TURN)
//            - counter width helper used by the filter and turnaround counters
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bidir_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_DRIVE = 2'b01,
      ST_TURN  = 2'b10
   } chan_state_t;

   // Width needed to hold 0..max_val. Never returns less than 1 so that a
   // zero-length turnaround still yields a legal (unused) counter vector.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

   // Widths for the default parameter set; channels derive their own from
   // cnt_width() with their actual FILTER_LEN / TURN_CYCLES.
   localparam int FILT_CNT_W_DEFAULT = $clog2(3 + 1);
   localparam int TURN_CNT_W_DEFAULT = $clog2(1 + 1);

endpackage : bidir_pkg
`default_nettype wire

// File: rtl/bidir_channel.sv
`default_nettype none
// ============================================================================
// Module   : bidir_channel
// Purpose  : One pad channel of the I/O bank.
//            Input path : SYNC_STAGES synchroniser -> glitch filter -> edge
//                         detector (rise/fall pulses, optionally masked while
//                         the channel is driving or turning around).
//            Output path: registered data / enable plus an OFF/DRIVE/TURN
//                         bus-turnaround state machine.
// Ports    : clk, rst_n      - clock, async active-low reset
//            pad_in          - raw pad level
//            in_en           - input enable (gates in_dat and edge pulses)
//            in_dat          - filtered input, gated by in_en
//            in_rise/in_fall - one-cycle filtered edge pulses
//            out_dat, out_en - fabric output data / drive request
//            pad_out, pad_en - registered pad data / driver enable
//            busy            - state is DRIVE or TURN
// Revision : 1.0 - initial release
// ============================================================================
module bidir_channel
   import bidir_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TURN_CYCLES = 1,
   parameter int ECHO_MASK   = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad_in,
   input  logic in_en,
   output logic in_dat,
   output logic in_rise,
   output logic in_fall,
   input  logic out_dat,
   input  logic out_en,
   output logic pad_out,
   output logic pad_en,
   output logic busy
);

   localparam int FCW = cnt_width(FILTER_LEN);
   localparam int TCW = cnt_width(TURN_CYCLES);
   localparam logic [FCW-1:0] FC_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [TCW-1:0] TC_LOAD = TCW'(TURN_CYCLES);
   localparam logic [TCW-1:0] TC_ONE  = TCW'(1);
   localparam bit             MASK_ON = (ECHO_MASK != 0);

   // ------------------------------------------------------------------
   // Input path
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic                   filt_q;
   logic [FCW-1:0]         fcnt_q;
   logic                   filt_flip;
   logic                   edge_ok;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Filter accepts the new level on the FILTER_LEN-th consecutive cycle of
   // disagreement; any return to the held level restarts the count.
   assign filt_flip = (sync_s != filt_q) && (fcnt_q == FC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b0;
         fcnt_q <= '0;
      end else if (sync_s == filt_q) begin
         fcnt_q <= '0;
      end else if (filt_flip) begin
         filt_q <= sync_s;
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + FCW'(1);
      end
   end

   // Edges are reported in the same cycle the filtered level changes.
   // With masking on, our own driven value looping back through the pad
   // must not look like an external event.
   assign edge_ok = in_en && !(MASK_ON && busy);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= filt_flip &&  sync_s && edge_ok;
         fall_q <= filt_flip && !sync_s && edge_ok;
      end
   end

   assign in_dat  = filt_q & in_en;
   assign in_rise = rise_q;
   assign in_fall = fall_q;

   // ------------------------------------------------------------------
   // Output path: turnaround FSM
   // ------------------------------------------------------------------
   chan_state_t    state_q;
   chan_state_t    state_d;
   logic [TCW-1:0] tcnt_q;
   logic [TCW-1:0] tcnt_d;
   logic           pad_en_q;
   logic           pad_q;
   logic           pad_en_d;
   logic           pad_d;

   // State register; pad outputs are registered alongside so that the
   // driver enable is a clean flop output and clears asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         tcnt_q   <= '0;
         pad_en_q <= 1'b0;
         pad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         pad_en_q <= pad_en_d;
         pad_q    <= pad_d;
      end
   end

   // Next-state logic. TURN always runs its full length; a request seen on
   // the final TURN cycle goes straight back to DRIVE.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         ST_OFF: begin
            if (out_en) state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (!out_en) begin
               if (TURN_CYCLES == 0) begin
                  state_d = ST_OFF;
               end else begin
                  state_d = ST_TURN;
                  tcnt_d  = TC_LOAD;
               end
            end
         end
         ST_TURN: begin
            if (tcnt_q <= TC_ONE) begin
               tcnt_d  = '0;
               state_d = out_en ? ST_DRIVE : ST_OFF;
            end else begin
               tcnt_d  = tcnt_q - TC_ONE;
            end
         end
         default: begin
            state_d = ST_OFF;
            tcnt_d  = '0;
         end
      endcase
   end

   // Output decode, taken from the next state so the registered outputs
   // line up with the state they describe.
   always_comb begin
      pad_en_d = (state_d == ST_DRIVE);
      pad_d    = pad_en_d ? out_dat : 1'b0;
      busy     = (state_q != ST_OFF);
   end

   assign pad_en  = pad_en_q;
   assign pad_out = pad_q;

endmodule : bidir_channel
`default_nettype wire

// File: rtl/bidir_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : bidir_io_bank
// Purpose  : Bank of WIDTH independent bidirectional pad channels sitting
//            between fabric logic and the physical I/O pads.
// Ports    : CLK, RST_N              - clock, async active-low reset
//            I_PAD, I_EN             - raw pad levels, input enables
//            I_DAT, I_RISE, I_FALL   - filtered data and edge pulses
//            O_DAT, O_EN             - fabric output data and drive request
//            O_PAD, O_PAD_EN         - registered pad data / driver enable
//            BUSY                    - channel in DRIVE or TURN
// Revision : 1.0 - initial release
// ============================================================================
module bidir_io_bank
   import bidir_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TURN_CYCLES = 1,
   parameter int ECHO_MASK   = 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] I_PAD,
   input  logic [WIDTH-1:0] I_EN,
   output logic [WIDTH-1:0] I_DAT,
   output logic [WIDTH-1:0] I_RISE,
   output logic [WIDTH-1:0] I_FALL,
   input  logic [WIDTH-1:0] O_DAT,
   input  logic [WIDTH-1:0] O_EN,
   output logic [WIDTH-1:0] O_PAD,
   output logic [WIDTH-1:0] O_PAD_EN,
   output logic [WIDTH-1:0] BUSY
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      bidir_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .TURN_CYCLES (TURN_CYCLES),
         .ECHO_MASK   (ECHO_MASK)
      ) u_chan (
         .clk     (CLK),
         .rst_n   (RST_N),
         .pad_in  (I_PAD[i]),
         .in_en   (I_EN[i]),
         .in_dat  (I_DAT[i]),
         .in_rise (I_RISE[i]),
         .in_fall (I_FALL[i]),
         .out_dat (O_DAT[i]),
         .out_en  (O_EN[i]),
         .pad_out (O_PAD[i]),
         .pad_en  (O_PAD_EN[i]),
         .busy    (BUSY[i])
      );
   end

endmodule : bidir_io_bank
`default_nettype wire
